// File: rtl/eq_i2s_tx_pkg.sv
// Shared I2S frame constants and slot/bit helpers for the equalizer audio path.
// Intended for reuse by the matching I2S receiver on the input side.
package eq_i2s_tx_pkg;

  localparam int I2S_DATA_W  = 16;
  localparam int I2S_SLOT_W  = 32;
  localparam int I2S_CLK_DIV = 2;

  typedef enum logic {
    I2S_LEFT  = 1'b0,
    I2S_RIGHT = 1'b1
  } i2s_chan_e;

  // Word select leads the data by one bit, so the right slot is flagged from k = slot_w-1.
  function automatic i2s_chan_e i2s_ws(input int k, input int slot_w);
    return ((k >= slot_w - 1) && (k <= 2 * slot_w - 2)) ? I2S_RIGHT : I2S_LEFT;
  endfunction

  function automatic logic i2s_bit_active(input int k, input int slot_w, input int data_w);
    return (k < data_w) || ((k >= slot_w) && (k < slot_w + data_w));
  endfunction

  function automatic int i2s_bit_pos(input int k, input int slot_w, input int data_w);
    return (k >= slot_w) ? (data_w - 1 - (k - slot_w)) : (data_w - 1 - k);
  endfunction

endpackage

// File: rtl/eq_i2s_tx_if.sv
// Sample handshake plus I2S pin bundle between the equalizer back end and the DAC transmitter.
interface eq_i2s_tx_if
  import eq_i2s_tx_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W
);

  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              bclk;
  logic              lrclk;
  logic              sdata;
  logic              underrun;

  modport master (
    output sample_in, sample_valid,
    input  sample_ready, bclk, lrclk, sdata, underrun
  );

  modport slave (
    input  sample_in, sample_valid,
    output sample_ready, bclk, lrclk, sdata, underrun
  );

endinterface

// File: rtl/eq_sample_fifo2.sv
// Two-entry valid/ready sample buffer; simultaneous push and pop keep the count unchanged.
module eq_sample_fifo2
  import eq_i2s_tx_pkg::*;
#(
  parameter int W = I2S_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] push_data_i,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_fire;
  logic         pop_fire;

  always_comb begin
    push_fire = push_valid_i && (count_q != 2'd2);
    pop_fire  = pop_i && (count_q != 2'd0);
    wr_ptr_d  = wr_ptr_q ^ push_fire;
    rd_ptr_d  = rd_ptr_q ^ pop_fire;
    count_d   = count_q;
    if (push_fire && !pop_fire) begin
      count_d = count_q + 2'd1;
    end else if (pop_fire && !push_fire) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign push_ready_o = (count_q != 2'd2);
  assign head_o       = mem_q[rd_ptr_q];
  assign empty_o      = (count_q == 2'd0);

endmodule

// File: rtl/eq_i2s_tx.sv
// I2S transmitter: buffers mono equalizer samples and sends each on both DAC channels.
// Define EQ_I2S_TX_UNDERRUN_HOLD_EN to repeat the previous sample on underrun instead of silence.
module eq_i2s_tx
  import eq_i2s_tx_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV,
  parameter int DATA_W  = I2S_DATA_W,
  parameter int SLOT_W  = I2S_SLOT_W
) (
  input logic        clk,
  input logic        rst_n,
  eq_i2s_tx_if.slave bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int K_W   = $clog2(2 * SLOT_W);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(2 * SLOT_W - 1);

  logic [DIV_W-1:0]  div_q, div_d;
  logic              bclk_q, bclk_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [DATA_W-1:0] frame_q, frame_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic              underrun_q, underrun_d;

  logic              div_tc;
  logic              bclk_fall;
  logic              frame_start;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_ready;
  logic [DATA_W-1:0] fifo_head;
  logic [IDX_W-1:0]  bit_idx;

  eq_sample_fifo2 #(
    .W(DATA_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_data_i  (bus.sample_in),
    .push_valid_i (bus.sample_valid),
    .push_ready_o (fifo_ready),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .empty_o      (fifo_empty)
  );

  always_comb begin
    div_tc      = (div_q == DIV_LAST);
    div_d       = div_tc ? '0 : div_q + DIV_W'(1);
    bclk_d      = bclk_q ^ div_tc;
    bclk_fall   = div_tc && bclk_q;
    frame_start = bclk_fall && (k_q == K_LAST);

    k_d        = k_q;
    frame_d    = frame_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    fifo_pop   = 1'b0;
    bit_idx    = '0;

    if (bclk_fall) begin
      k_d = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
    end

    // Emptiness is judged on the registered count, so a same-cycle push waits a frame.
    if (frame_start) begin
      underrun_d = fifo_empty;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        frame_d  = fifo_head;
      end else begin
`ifdef EQ_I2S_TX_UNDERRUN_HOLD_EN
        frame_d = frame_q;
`else
        frame_d = '0;
`endif
      end
    end

    // Pins change only on the falling edge; the new frame value feeds bit 0 directly.
    if (bclk_fall) begin
      lrclk_d = (i2s_ws(int'(k_d), SLOT_W) == I2S_RIGHT);
      bit_idx = IDX_W'(i2s_bit_pos(int'(k_d), SLOT_W, DATA_W));
      sdata_d = i2s_bit_active(int'(k_d), SLOT_W, DATA_W) && frame_d[bit_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      k_q        <= K_LAST;
      frame_q    <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      k_q        <= k_d;
      frame_q    <= frame_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.sample_ready = fifo_ready;
  assign bus.bclk         = bclk_q;
  assign bus.lrclk        = lrclk_q;
  assign bus.sdata        = sdata_q;
  assign bus.underrun     = underrun_q;

endmodule

// File: doc/eq_i2s_tx.md
# eq_i2s_tx

Serial audio transmitter at the output end of the 8-band equalizer: accepts 16-bit equalized samples on a valid/ready strobe and serializes them to an external stereo DAC in I2S format. The mono sample is sent on both channels. The block generates BCLK and LRCLK from the system clock and buffers up to two samples. If the buffer is empty at a frame boundary, it flags an underrun.

## Interface
- CLK_DIV, 2: system clocks per BCLK half-period; ≥1
- DATA_W, 16: sample width; ≤ SLOT_W
- SLOT_W, 32: BCLK bits per channel slot; frame = 2·SLOT_W bits
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_in  in  DATA_W  signed equalizer output sample
- sample_valid  in  1  sample_in valid this cycle
- sample_ready  out  1  buffer can accept; transfer when valid && ready
- bclk  out  1  serial bit clock to DAC
- lrclk  out  1  word select; 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- underrun  out  1  one-clk pulse when a frame starts with the buffer empty

One clock (clk); reset is asynchronous and active-low (rst_n).

## Operation
- Buffer: 2-entry FIFO. sample_ready = !full. A push and a pop in the same cycle leave the count unchanged. A pop when empty never happens; that case takes the underrun path.
- Divider: counter runs 0..CLK_DIV-1. At terminal count, bclk toggles.
- Bit index k runs 0..2·SLOT_W-1. It advances on each bclk 1→0 toggle and wraps from 2·SLOT_W-1 to 0.
- Frame start (k becomes 0):
  - Buffer non-empty: pop the head into the frame register.
  - Buffer empty: underrun pulses, and the frame register loads the fallback value (see Configuration).
- All outputs update only on the bclk falling edge. Data is stable across the DAC's rising-edge capture.
- lrclk = 1 for k in [SLOT_W-1, 2·SLOT_W-2]; 0 otherwise. It leads data by one bit, per I2S.
- sdata:
  - k in [0, DATA_W-1] → frame[DATA_W-1-k]
  - k in [SLOT_W, SLOT_W+DATA_W-1] → frame[DATA_W-1-(k-SLOT_W)]
  - all other bits → 0
- Sample is two's-complement and passed through unmodified. No rounding or saturation.
- Optional state machine view: IDLE_RESET (wait for first falling edge) → LEFT (k < SLOT_W) → RIGHT → LEFT…

## Timing
- Reset values: bclk=0, lrclk=0, sdata=0, underrun=0, sample_ready=1, FIFO empty, k=2·SLOT_W-1, divider=0, frame register=0.
- First bclk rise is CLK_DIV clks after reset release. The first falling edge, at 2·CLK_DIV clks, is frame start k=0.
- Frame period: 4·SLOT_W·CLK_DIV clks.
- Latency: a sample pushed into an empty FIFO reaches sdata (its MSB) at the next frame start. It must be accepted at least one clk before that falling edge.
- Push on the same clk as a frame-start pop with the FIFO empty: that frame underruns, and the sample is kept for the next frame.
- Reset asserted mid-frame clears everything immediately (async). Outputs return to reset values and no partial frame resumes.
- underrun is high for exactly the one clk in which k becomes 0.

## Configuration
- EQ_I2S_TX_UNDERRUN_HOLD_EN
  - Defined: on underrun, the frame register keeps the previous sample (the last frame repeats).
  - Undefined: on underrun, the frame register loads 0 (silence).
  - underrun pulses in both builds.

## Structure
- Shared package: I2S frame constants (default DATA_W, SLOT_W, CLK_DIV) and the lrclk/bit-index helper functions, reused by a future I2S receiver on the input side.
- One sub-module is natural: eq_sample_fifo2, the 2-entry valid/ready FIFO.
- Divider, bit counter and serializer live in eq_i2s_tx.

## Test plan
CLK_DIV=2, DATA_W=16, SLOT_W=32 throughout; frame = 256 clk.
- Reset: after reset release, bclk first rises at clk 2 and first falls at clk 4. lrclk=0, sdata=0 and sample_ready=1 until then.
- Single sample 16'hA5C3 pushed before the first frame:
  - Left slot sdata = 1010010111000011 then 16 zeros, and the right slot is identical.
  - lrclk rises at k=31 and falls at k=63.
  - underrun stays 0 for that frame.
- Back-to-back pushes of 16'h7FFF, 16'h8000, 16'h1234: the third is stalled by sample_ready=0 until the first frame pops. Frames then carry the three samples in order.
- No push after 16'h0F0F: the next frame pulses underrun for 1 clk. sdata carries 16'h0F0F repeated with HOLD_EN, all zeros without.
- Push coinciding with the frame-start clk when empty: underrun for that frame, and the sample appears in the following frame.
- rst_n asserted at k=40 mid-right-slot: outputs go to reset values immediately. After release, the sequence restarts exactly as in the reset scenario.
